serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes difference = operand_A - operand_B, LSB first, one bit per clock.
- Datapath and handshake mirror serial_adder: start/busy/done, registered results.
- Serves as the inverse-operation companion to serial_adder in the serial-arithmetic unit.
- Also acts as a cross-check: a bench can add with serial_adder and subtract back with this block to recover the original operand.

Parameters:
WIDTH, 32, operand and result width in bits (must be ≥2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset; asynchronous, active-low
start  input  1  request; sampled only in IDLE
operand_A  input  WIDTH  minuend; captured on the accepting edge
operand_B  input  WIDTH  subtrahend; captured on the accepting edge
difference  output  WIDTH  registered result of A - B (mod 2^WIDTH)
borrow_out  output  1  registered final borrow; 1 iff A < B (unsigned)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse

Behaviour:
- Single clock domain.
- Reset: rst low (asynchronous, active-low) forces all state at once.
  - State = IDLE; difference = 0, borrow_out = 0, busy = 0, done = 0.
  - Internal shift registers, borrow flop and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, accepting edge (start = 1):
  - a_sh <= operand_A, b_sh <= operand_B.
  - br <= 0, cnt <= 0.
  - Next state RUN.
  - difference and borrow_out keep their previous values until DONE.
- IDLE, start = 0: hold.
- RUN, every edge:
  - Bit cell on a_sh[0], b_sh[0], br:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
  - d shifts into diff_sh MSB; diff_sh, a_sh and b_sh shift right by one.
  - br <= br_next; cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1:
    - Next state DONE.
    - difference <= final shifted value, including this cycle's bit.
    - borrow_out <= br_next.
- DONE: done = 1 for exactly this one cycle; next edge returns to IDLE.
- Latency:
  - Accepting edge E0, then WIDTH RUN edges E1..E_WIDTH.
  - done high in the cycle following E_WIDTH; results valid from that cycle.
  - Results hold until the next operation's DONE update or reset.
  - Next start is accepted at the earliest on edge E_WIDTH+2.
- start while busy is ignored: no queueing, no restart. Operand changes during RUN have no effect.
- start held high continuously: back-to-back operations, one every WIDTH+2 cycles.
- Arithmetic:
  - Modulo 2^WIDTH; no signed interpretation.
  - A == B gives difference 0, borrow 0.
  - 0 - 1 wraps to all ones with borrow 1.
- cnt width = $clog2(WIDTH)+1 so cnt == WIDTH-1 is representable; no wrap inside RUN.
- Reset mid-RUN:
  - Immediate return to IDLE; partial result discarded.
  - difference and borrow_out cleared; no done pulse.
- Outputs are all register-driven; no combinational path from inputs to outputs.

Decomposition:
- Shared package serial_arith_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Default WIDTH constant (32).
  - Width function for cnt.
  - Package is reused by serial_adder.
- One natural sub-module: full_subtractor_bit.
  - Combinational; inputs a, b, bin; outputs d, bout.
  - Instantiated once and fed from the shift-register LSBs.
- FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
1. Basic and wrap: 00000002 - 00000001 -> 00000001, borrow 0. 00000000 - 00000001 -> FFFFFFFF, borrow 1. FFFFFFFF - FFFFFFFF -> 00000000, borrow 0.
2. Borrow propagation and large values: 80000000 - 00000001 -> 7FFFFFFF, borrow 0. DEADBEEF - CAFEBABE -> 13AF0431, borrow 0. CAFEBABE - DEADBEEF -> EC50FBCF, borrow 1.
3. Latency: start pulsed for one cycle at edge E0 -> busy high from E0; done high exactly one cycle after E32; done low and busy low after E33.
4. Busy protection: second start with new operands at E5 -> ignored; result equals the first operation; next start at E34 is accepted.
5. Reset mid-operation: rst driven low asynchronously between E10 and E11 -> outputs 0 immediately, no done pulse; a fresh 12345678 - 00000000 then yields 12345678, borrow 0.
6. Round-trip with serial_adder, 1000 random pairs: (A + B) mod 2^32 fed back with B -> A; borrow_out equals the adder's carry_out.

Source files
------------

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared types and helpers for the bit-serial arithmetic unit
//                (serial_adder / serial_subtractor).
//  Revision    : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

    // Control FSM states shared by every bit-serial operator
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand / result width
    localparam int DEFAULT_WIDTH = 32;

    // Bit counter width: one extra bit so WIDTH-1 is always representable
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Request / result bundle of the bit-serial subtractor.
//                The master issues operands and start; the slave returns
//                registered results with busy/done status.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output operand_A,
        output operand_B,
        input  difference,
        input  borrow_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  operand_A,
        input  operand_B,
        output difference,
        output borrow_out,
        output busy,
        output done
    );

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/full_subtractor_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor_bit
//  Description : One-bit full subtractor cell, a - b - bin.
//  Revision    : 1.0  initial release
// ============================================================================
module full_subtractor_bit (
    input  wire logic a,
    input  wire logic b,
    input  wire logic bin,
    output wire logic d,
    output wire logic bout
);

    // Borrow out when b exceeds a, or when a == b and a borrow is pending
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor, difference = A - B
//                (mod 2^WIDTH), LSB first, one bit per clock. Results and
//                status are register-driven and hold until the next
//                completed operation or reset.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst,    // asynchronous, active-low
    serial_subtractor_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

    // Reject degenerate widths at elaboration
    if (WIDTH < 2) begin : g_width_check
        $error("serial_subtractor: WIDTH must be at least 2");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_difference;
    logic             r_borrow_out;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_diff_next;

    // Single bit cell fed from the operand shift-register LSBs
    full_subtractor_bit u_bit (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // New result bit enters at the MSB so the LSB-first stream lands in place
    assign w_diff_next = {w_d, r_diff_sh[WIDTH-1:1]};

    // Control FSM, serial datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_diff_sh    <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_difference <= '0;
            r_borrow_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.operand_A;
                        r_b_sh  <= bus.operand_B;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_diff_sh <= w_diff_next;
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_br      <= w_bout;
                    r_cnt     <= r_cnt + CW'(1);
                    // Last bit: publish the full result including this bit
                    if (r_cnt == C_LAST_BIT) begin
                        r_difference <= w_diff_next;
                        r_borrow_out <= w_bout;
                        r_done       <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.difference = r_difference;
    assign bus.borrow_out = r_borrow_out;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed self-checking bench for serial_subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it disagrees
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for the done cycle
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic ok);
        int n;
        @(negedge clk);
        bus.operand_A = a;
        bus.operand_B = b;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.done === 1'b1);
    endtask

    // Directed operation with hand-computed result and borrow
    task automatic op_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_b);
        logic ok;
        run_op(a, b, ok);
        chk({tag, "_done"}, 64'(ok), 64'(1'b1));
        chk({tag, "_diff"}, 64'(bus.difference), 64'(exp_d));
        chk({tag, "_borrow"}, 64'(bus.borrow_out), 64'(exp_b));
    endtask

    initial begin
        logic        ok;
        logic [32:0] sum;
        logic [31:0] ra;
        logic [31:0] rb;
        int          pulses;

        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.operand_A = '0;
        bus.operand_B = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_diff", 64'(bus.difference), 64'd0);
        chk("rst_borrow", 64'(bus.borrow_out), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic and wrap
        op_chk("two_minus_one", 32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 1'b0);
        op_chk("zero_minus_one", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        op_chk("equal_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

        // Borrow propagation and large values
        op_chk("msb_minus_one", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
        op_chk("dead_cafe", 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h13AF_0431, 1'b0);
        op_chk("cafe_dead", 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hEC50_FBCF, 1'b1);

        // Latency: E0 accept, done after E32, idle after E33
        @(negedge clk);
        bus.operand_A = 32'h0000_0010;
        bus.operand_B = 32'h0000_0003;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("lat_busy_e0", 64'(bus.busy), 64'd1);
        chk("lat_done_e0", 64'(bus.done), 64'd0);
        repeat (31) @(negedge clk);
        chk("lat_done_e31", 64'(bus.done), 64'd0);
        chk("lat_diff_held_e31", 64'(bus.difference), 64'hEC50_FBCF);
        @(negedge clk);
        chk("lat_done_e32", 64'(bus.done), 64'd1);
        chk("lat_busy_e32", 64'(bus.busy), 64'd1);
        chk("lat_diff_e32", 64'(bus.difference), 64'h0000_000D);
        @(negedge clk);
        chk("lat_done_e33", 64'(bus.done), 64'd0);
        chk("lat_busy_e33", 64'(bus.busy), 64'd0);

        // Busy protection: start at E5 ignored, start at E34 accepted
        @(negedge clk);
        bus.operand_A = 32'h0000_0100;
        bus.operand_B = 32'h0000_0001;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.operand_A = 32'h0000_0005;
        bus.operand_B = 32'h0000_0009;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (27) @(negedge clk);
        chk("busy_prot_done", 64'(bus.done), 64'd1);
        chk("busy_prot_diff", 64'(bus.difference), 64'h0000_00FF);
        chk("busy_prot_borrow", 64'(bus.borrow_out), 64'd0);
        @(negedge clk);
        chk("busy_prot_done_e33", 64'(bus.done), 64'd0);
        bus.operand_A = 32'h0000_0007;
        bus.operand_B = 32'h0000_0003;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("e34_accept_busy", 64'(bus.busy), 64'd1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.done === 1'b1);
        end
        chk("e34_done", 64'(ok), 64'd1);
        chk("e34_diff", 64'(bus.difference), 64'h0000_0004);

        // Reset mid-operation: hold a nonzero borrow result first
        op_chk("pre_reset", 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        bus.operand_A = 32'hFFFF_0000;
        bus.operand_B = 32'h0000_0001;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_diff", 64'(bus.difference), 64'd0);
        chk("midrst_borrow", 64'(bus.borrow_out), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("midrst_no_done", 64'(pulses), 64'd0);
        op_chk("after_reset", 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0);

        // Round trip: (A + B) mod 2^32 - B recovers A, borrow equals carry
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            sum = {1'b0, ra} + {1'b0, rb};
            run_op(sum[31:0], rb, ok);
            chk("rt_done", 64'(ok), 64'd1);
            chk("rt_diff", 64'(bus.difference), 64'(ra));
            chk("rt_borrow", 64'(bus.borrow_out), 64'(sum[32]));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_subtractor
`default_nettype wire
